// File: rtl/regfile_mp_pkg.sv
// Shared constants, helpers and types for the multi-port register file.
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One writeback request, sized for the default configuration.
  typedef struct packed {
    logic                         en;
    logic [$clog2(DEF_DEPTH)-1:0] addr;
    logic [DEF_DATA_W-1:0]        data;
  } wr_req_t;

endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-write scoreboard: busy vector with set-over-clear priority and a
// registered population count of the next-state busy bits.
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ZERO_R0 = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DEPTH-1:0]           clr_mask_i,
  input  logic                       sb_set_i,
  input  logic [addr_w(DEPTH)-1:0]   sb_addr_i,
  output logic [DEPTH-1:0]           busy_o,
  output logic [addr_w(DEPTH):0]     busy_cnt_o
);

  localparam int AW = addr_w(DEPTH);

  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_cnt;
  logic [DEPTH-1:0] w_setMask;
  logic [DEPTH-1:0] w_busyNext;
  logic [AW:0]      w_cntNext;

  // Set is applied after clear so a new issue behind a retiring write keeps the register busy.
  always_comb begin
    w_setMask = '0;
    if (sb_set_i && !((ZERO_R0 != 0) && (sb_addr_i == '0))) begin
      w_setMask[sb_addr_i] = 1'b1;
    end
    w_busyNext = (r_busy & ~clr_mask_i) | w_setMask;
    if (ZERO_R0 != 0) begin
      w_busyNext[0] = 1'b0;
    end
    w_cntNext = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cntNext = w_cntNext + {{AW{1'b0}}, w_busyNext[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busyNext;
      r_cnt  <= w_cntNext;
    end
  end

  assign busy_o     = r_busy;
  assign busy_cnt_o = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with pending-write scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_WR-1:0]                 wr_en_i,
  input  logic [NUM_WR*addr_w(DEPTH)-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]          wr_data_i,
  input  logic [NUM_RD*addr_w(DEPTH)-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]          rd_data_o,
  output logic [NUM_RD-1:0]                 rd_busy_o,
  input  logic                              sb_set_i,
  input  logic [addr_w(DEPTH)-1:0]          sb_addr_i,
  output logic [addr_w(DEPTH):0]            busy_cnt_o
);

  localparam int AW = addr_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_wrMask;
  logic [DATA_W-1:0] w_wrData [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic [AW-1:0]     w_rdAddr [NUM_RD];

  // Ports are scanned in ascending order so the highest enabled port to an address wins.
  always_comb begin
    w_wrMask = '0;
    for (int d = 0; d < DEPTH; d++) begin
      w_wrData[d] = '0;
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) begin
        w_wrMask[wr_addr_i[w*AW +: AW]] = 1'b1;
        w_wrData[wr_addr_i[w*AW +: AW]] = wr_data_i[w*DATA_W +: DATA_W];
      end
    end
    if (ZERO_R0 != 0) begin
      w_wrMask[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        r_mem[d] <= '0;
      end
    end else begin
      for (int d = 0; d < DEPTH; d++) begin
        if (w_wrMask[d]) begin
          r_mem[d] <= w_wrData[d];
        end
      end
    end
  end

  regfile_mp_sb #(
    .DEPTH   (DEPTH),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .clr_mask_i (w_wrMask),
    .sb_set_i   (sb_set_i),
    .sb_addr_i  (sb_addr_i),
    .busy_o     (w_busy),
    .busy_cnt_o (busy_cnt_o)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rdAddr
    assign w_rdAddr[p] = rd_addr_i[p*AW +: AW];
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_o[p*DATA_W +: DATA_W] = r_mem[w_rdAddr[p]];
      rd_busy_o[p]                  = w_busy[w_rdAddr[p]];
`ifdef REGFILE_MP_BYPASS_EN
      if (w_wrMask[w_rdAddr[p]]) begin
        rd_data_o[p*DATA_W +: DATA_W] = w_wrData[w_rdAddr[p]];
        rd_busy_o[p]                  = sb_set_i && (sb_addr_i == w_rdAddr[p]);
      end
`endif
      if ((ZERO_R0 != 0) && (w_rdAddr[p] == '0)) begin
        rd_data_o[p*DATA_W +: DATA_W] = '0;
        rd_busy_o[p]                  = 1'b0;
      end
    end
  end

endmodule
